letc_core_imss_fetch_queue: RTL and testbench

- Parametrised in-order tracking queue between fetch stage 1, the instruction memory subsystem (IMSS) and fetch stage 2.
- Replaces the single-beat, handshake-less fetch/IMSS connection with valid/ready handshakes and up to DEPTH outstanding requests.
- Adds a flush that kills in-flight fetches (redirect/branch mispredict) without stalling the memory side.
- Each entry holds the virtual address, response data and illegal flag; fetch 2 sees responses in request order.

---
 rtl/letc_core_imss_fetch_queue_if.sv | 41 ++++
 rtl/letc_core_imss_fetch_queue.sv | 114 +++++++++++
 tb/tb_letc_core_imss_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/letc_core_imss_fetch_queue_if.sv
// Fetch 1 / IMSS / fetch 2 handshake bundle around the fetch tracking queue.
// master: the queue itself; slave: the surrounding fetch stages and IMSS.
interface letc_core_imss_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f1_req_valid;
    logic              f1_req_ready;
    logic [ADDR_W-1:0] f1_req_vaddr;
    logic              imss_req_valid;
    logic              imss_req_ready;
    logic [ADDR_W-1:0] imss_req_vaddr;
    logic              imss_rsp_valid;
    logic              imss_rsp_illegal;
    logic [DATA_W-1:0] imss_rsp_data;
    logic              f2_rsp_valid;
    logic              f2_rsp_ready;
    logic [ADDR_W-1:0] f2_rsp_vaddr;
    logic [DATA_W-1:0] f2_rsp_data;
    logic              f2_rsp_illegal;

    modport master (
        input  f1_req_valid, f1_req_vaddr,
        output f1_req_ready,
        output imss_req_valid, imss_req_vaddr,
        input  imss_req_ready,
        input  imss_rsp_valid, imss_rsp_illegal, imss_rsp_data,
        output f2_rsp_valid, f2_rsp_vaddr, f2_rsp_data, f2_rsp_illegal,
        input  f2_rsp_ready
    );

    modport slave (
        output f1_req_valid, f1_req_vaddr,
        input  f1_req_ready,
        input  imss_req_valid, imss_req_vaddr,
        output imss_req_ready,
        output imss_rsp_valid, imss_rsp_illegal, imss_rsp_data,
        input  f2_rsp_valid, f2_rsp_vaddr, f2_rsp_data, f2_rsp_illegal,
        output f2_rsp_ready
    );
endinterface

// File: rtl/letc_core_imss_fetch_queue.sv
// In-order tracking queue between fetch 1, IMSS and fetch 2; flush kills in-flight entries.
// Latency: IMSS response to f2 is 1 cycle (0 with LETC_IMSS_FETCH_QUEUE_BYPASS_EN on an unkilled head).
// Backpressure: f1 stalls on IMSS not ready or queue full; IMSS responses are never stalled.
module letc_core_imss_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    letc_core_imss_fetch_queue_if.master bus,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int OW = $clog2(DEPTH + 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_ptr, fill_ptr, tail_ptr;
    logic [IW-1:0] head_idx, fill_idx, tail_idx;

    logic [ADDR_W-1:0] vaddr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [DEPTH-1:0]  illegal_mem;
    logic [DEPTH-1:0]  filled, killed, filled_nxt, killed_nxt;

    logic full, head_alloc, head_filled, head_killed;
    logic rsp_ok, bypass, f1_ready, f2_valid;
    logic alloc, f2_pop, auto_pop, pop;

    assign head_idx = head_ptr[IW-1:0];
    assign fill_idx = fill_ptr[IW-1:0];
    assign tail_idx = tail_ptr[IW-1:0];

    assign occupancy   = OW'(tail_ptr - head_ptr);
    assign full        = (occupancy == OW'(DEPTH));
    assign head_alloc  = (head_ptr != tail_ptr);
    assign head_filled = filled[head_idx];
    assign head_killed = killed[head_idx];

    // Request path is a pure passthrough, gated only by registered fullness.
    assign f1_ready            = !rst && bus.imss_req_ready && !full;
    assign bus.f1_req_ready    = f1_ready;
    assign bus.imss_req_valid  = !rst && bus.f1_req_valid && !full;
    assign bus.imss_req_vaddr  = bus.f1_req_vaddr;
    assign alloc               = bus.f1_req_valid && f1_ready;

    // A response with no unfilled entry is a protocol error and is dropped.
    assign rsp_ok = bus.imss_rsp_valid && (fill_ptr != tail_ptr);

`ifdef LETC_IMSS_FETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_ok && (fill_ptr == head_ptr) && !head_killed && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign f2_valid           = !rst && !flush && head_alloc && !head_killed
                                && (head_filled || bypass);
    assign bus.f2_rsp_valid   = f2_valid;
    assign bus.f2_rsp_vaddr   = vaddr_mem[head_idx];
    assign bus.f2_rsp_data    = bypass ? bus.imss_rsp_data    : data_mem[head_idx];
    assign bus.f2_rsp_illegal = bypass ? bus.imss_rsp_illegal : illegal_mem[head_idx];

    // Killed entries retire silently once their response has been absorbed.
    assign f2_pop   = f2_valid && bus.f2_rsp_ready;
    assign auto_pop = head_alloc && head_filled && head_killed;
    assign pop      = f2_pop || auto_pop;

    always_comb begin
        filled_nxt = filled;
        killed_nxt = killed;
        if (flush)
            killed_nxt = '1;
        if (rsp_ok)
            filled_nxt[fill_idx] = 1'b1;
        // The same-cycle allocation postdates the flush, so it starts live.
        if (alloc) begin
            filled_nxt[tail_idx] = 1'b0;
            killed_nxt[tail_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            filled   <= '0;
            killed   <= '0;
        end else begin
            if (alloc)  tail_ptr <= tail_ptr + PW'(1);
            if (rsp_ok) fill_ptr <= fill_ptr + PW'(1);
            if (pop)    head_ptr <= head_ptr + PW'(1);
            filled <= filled_nxt;
            killed <= killed_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc)
            vaddr_mem[tail_idx] <= bus.f1_req_vaddr;
        if (rsp_ok) begin
            data_mem[fill_idx]    <= bus.imss_rsp_data;
            illegal_mem[fill_idx] <= bus.imss_rsp_illegal;
        end
    end

`ifndef SYNTHESIS
    rsp_without_entry: assert property (@(posedge clk) disable iff (rst)
        bus.imss_rsp_valid |-> (fill_ptr != tail_ptr))
        else $error("imss_rsp_valid with no outstanding request");
`endif
endmodule

// File: tb/tb_letc_core_imss_fetch_queue.sv
// Directed + randomized bench for letc_core_imss_fetch_queue against a queue-based reference model.
// Model tracks entries as a list; the head is the front, responses fill the first unfilled entry.
module tb_letc_core_imss_fetch_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] occupancy;

    letc_core_imss_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    letc_core_imss_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] vaddr;
        logic [31:0] data;
        logic        ill;
        logic        filled;
        logic        killed;
    } ent_t;

    ent_t mq[$];
    ent_t dut_log[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst                  = 1'b0;
        flush                = 1'b0;
        bus.f1_req_valid     = 1'b0;
        bus.f1_req_vaddr     = '0;
        bus.imss_req_ready   = 1'b1;
        bus.imss_rsp_valid   = 1'b0;
        bus.imss_rsp_illegal = 1'b0;
        bus.imss_rsp_data    = '0;
        bus.f2_rsp_ready     = 1'b1;
    endtask

    function automatic int first_unfilled();
        for (int i = 0; i < mq.size(); i++)
            if (!mq[i].filled) return i;
        return -1;
    endfunction

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cyc();
        int   fi;
        logic full, e_f1r, e_iv, has_rsp, byp, e_f2v, auto_pop;
        ent_t e;
        #1;
        full    = (mq.size() == DEPTH);
        e_f1r   = !rst && bus.imss_req_ready && !full;
        e_iv    = !rst && bus.f1_req_valid && !full;
        fi      = first_unfilled();
        has_rsp = bus.imss_rsp_valid && (fi >= 0);
        byp     = 1'b0;
`ifdef LETC_IMSS_FETCH_QUEUE_BYPASS_EN
        byp     = has_rsp && (fi == 0) && !mq[0].killed && !flush;
`endif
        e_f2v   = !rst && !flush && (mq.size() > 0) && !mq[0].killed && (mq[0].filled || byp);

        chk("f1_req_ready",   32'(bus.f1_req_ready),   32'(e_f1r));
        chk("imss_req_valid", 32'(bus.imss_req_valid), 32'(e_iv));
        chk("imss_req_vaddr", bus.imss_req_vaddr,      bus.f1_req_vaddr);
        chk("f2_rsp_valid",   32'(bus.f2_rsp_valid),   32'(e_f2v));
        if (!rst)
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
        if (e_f2v) begin
            e = mq[0];
            if (byp) begin
                e.data = bus.imss_rsp_data;
                e.ill  = bus.imss_rsp_illegal;
            end
            chk("f2_rsp_vaddr",   bus.f2_rsp_vaddr,          e.vaddr);
            chk("f2_rsp_data",    bus.f2_rsp_data,           e.data);
            chk("f2_rsp_illegal", 32'(bus.f2_rsp_illegal),   32'(e.ill));
        end
        if (bus.f2_rsp_valid && bus.f2_rsp_ready) begin
            e.vaddr  = bus.f2_rsp_vaddr;
            e.data   = bus.f2_rsp_data;
            e.ill    = bus.f2_rsp_illegal;
            e.filled = 1'b1;
            e.killed = 1'b0;
            dut_log.push_back(e);
        end

        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            auto_pop = (mq.size() > 0) && mq[0].filled && mq[0].killed;
            if (has_rsp) begin
                e        = mq[fi];
                e.data   = bus.imss_rsp_data;
                e.ill    = bus.imss_rsp_illegal;
                e.filled = 1'b1;
                mq[fi]   = e;
            end
            if (flush) begin
                for (int i = 0; i < mq.size(); i++) begin
                    e        = mq[i];
                    e.killed = 1'b1;
                    mq[i]    = e;
                end
            end
            if ((e_f2v && bus.f2_rsp_ready) || auto_pop)
                void'(mq.pop_front());
            if (bus.f1_req_valid && e_f1r)
                mq.push_back('{vaddr: bus.f1_req_vaddr, data: 32'h0, ill: 1'b0,
                               filled: 1'b0, killed: 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] va);
        bus.f1_req_valid = 1'b1;
        bus.f1_req_vaddr = va;
        cyc();
        bus.f1_req_valid = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] d, input logic il);
        bus.imss_rsp_valid   = 1'b1;
        bus.imss_rsp_data    = d;
        bus.imss_rsp_illegal = il;
        cyc();
        bus.imss_rsp_valid   = 1'b0;
        bus.imss_rsp_illegal = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Single fetch
        dut_log.delete();
        req(32'h8000_0000);
        cyc();
        rsp(32'h0000_0013, 1'b0);
        cyc();
        cyc();
        chk("t1_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) begin
            chk("t1_vaddr", dut_log[0].vaddr,    32'h8000_0000);
            chk("t1_data",  dut_log[0].data,     32'h0000_0013);
            chk("t1_ill",   32'(dut_log[0].ill), 32'd0);
        end
        chk("t1_occ", 32'(occupancy), 32'd0);

        // Fill to DEPTH, fifth request refused, then in-order drain
        dut_log.delete();
        for (int i = 0; i < 5; i++) begin
            bus.f1_req_valid = 1'b1;
            bus.f1_req_vaddr = 32'h1000 + 32'(4 * i);
            if (i == 4) begin
                #1;
                chk("t2_full_ready", 32'(bus.f1_req_ready), 32'd0);
            end
            cyc();
        end
        bus.f1_req_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            rsp(32'h100 + 32'(i), 1'b0);
        cyc();
        cyc();
        chk("t2_count", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++)
            chk("t2_order", dut_log[i].vaddr, 32'h1000 + 32'(4 * i));

        // Flush with 2 filled + 1 pending, new request in the flush cycle survives
        dut_log.delete();
        bus.f2_rsp_ready = 1'b0;
        req(32'h3000);
        req(32'h3004);
        req(32'h3008);
        rsp(32'hA0, 1'b0);
        rsp(32'hA4, 1'b0);
        flush            = 1'b1;
        bus.f1_req_valid = 1'b1;
        bus.f1_req_vaddr = 32'h2000;
        cyc();
        flush            = 1'b0;
        bus.f1_req_valid = 1'b0;
        bus.f2_rsp_ready = 1'b1;
        rsp(32'hA8, 1'b0);
        rsp(32'h2222, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        chk("t3_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) begin
            chk("t3_vaddr", dut_log[0].vaddr, 32'h2000);
            chk("t3_data",  dut_log[0].data,  32'h2222);
        end
        chk("t3_occ", 32'(occupancy), 32'd0);

        // Fetch 2 stall with 4 filled entries
        dut_log.delete();
        bus.f2_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) req(32'h5000 + 32'(4 * i));
        for (int i = 0; i < 4; i++) rsp(32'hC000 + 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_hold_valid", 32'(bus.f2_rsp_valid), 32'd1);
            chk("t4_hold_vaddr", bus.f2_rsp_vaddr,      32'h5000);
            chk("t4_hold_data",  bus.f2_rsp_data,       32'hC000);
            cyc();
        end
        bus.f2_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("t4_count", 32'(dut_log.size()), 32'd4);
        chk("t4_occ",   32'(occupancy),      32'd0);

        // Illegal flag on one entry only
        dut_log.delete();
        req(32'hDEAD_BEDC);
        req(32'hDEAD_BEE0);
        req(32'hDEAD_BEE4);
        rsp(32'h11, 1'b0);
        rsp(32'h22, 1'b1);
        rsp(32'h33, 1'b0);
        cyc();
        cyc();
        chk("t5_count", 32'(dut_log.size()), 32'd3);
        if (dut_log.size() == 3) begin
            chk("t5_ill0",  32'(dut_log[0].ill), 32'd0);
            chk("t5_ill1",  32'(dut_log[1].ill), 32'd1);
            chk("t5_vaddr", dut_log[1].vaddr,    32'hDEAD_BEE0);
            chk("t5_ill2",  32'(dut_log[2].ill), 32'd0);
        end

        // Reset with 3 outstanding, then a fresh fetch
        dut_log.delete();
        req(32'h6000);
        req(32'h6004);
        req(32'h6008);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_occ",   32'(occupancy),        32'd0);
        chk("t6_f2vld", 32'(bus.f2_rsp_valid), 32'd0);
        req(32'h4);
        rsp(32'h77, 1'b0);
        cyc();
        cyc();
        chk("t6_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) begin
            chk("t6_vaddr", dut_log[0].vaddr, 32'h4);
            chk("t6_data",  dut_log[0].data,  32'h77);
        end

        // Randomized traffic; responses only ever target an unfilled model entry
        for (int n = 0; n < 3000; n++) begin
            rst                  = ($urandom_range(0, 299) == 0);
            flush                = ($urandom_range(0, 15) == 0);
            bus.f1_req_valid     = $urandom_range(0, 1) == 1;
            bus.f1_req_vaddr     = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            bus.imss_req_ready   = $urandom_range(0, 3) != 0;
            bus.imss_rsp_valid   = (first_unfilled() >= 0) && ($urandom_range(0, 1) == 1);
            bus.imss_rsp_data    = $urandom;
            bus.imss_rsp_illegal = ($urandom_range(0, 9) == 0);
            bus.f2_rsp_ready     = $urandom_range(0, 4) > 1;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
